// File: rtl/rf_sb_multiport_pkg.sv
// Shared definitions for the multiport register file: clear-engine state encoding and port slicing.
// Optional feature macro used by the top: RF_BYPASS_EN (write-to-read bypass).
`ifndef RF_PKG_MACROS
`define RF_PKG_MACROS
`define RF_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package rf_pkg;
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_e;
endpackage

// File: rtl/rf_sb_multiport_if.sv
// Decode/writeback bus of the register file: write port, read ports, reservation and bulk clear.
interface rf_sb_multiport_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(DEPTH);

  logic                 we;
  logic [AW-1:0]        wa;
  logic [WIDTH-1:0]     wd;
  logic [NRD*AW-1:0]    ra;
  logic [NRD*WIDTH-1:0] rd;
  logic [NRD-1:0]       rbusy;
  logic                 rsv;
  logic [AW-1:0]        rsv_a;
  logic                 clr_start;
  logic                 clr_busy;

  modport master (
    output we, wa, wd, ra, rsv, rsv_a, clr_start,
    input  rd, rbusy, clr_busy
  );

  modport slave (
    input  we, wa, wd, ra, rsv, rsv_a, clr_start,
    output rd, rbusy, clr_busy
  );
endinterface

// File: rtl/rf_sb_multiport_clear_fsm.sv
// Sequential bulk-clear engine: walks every register address once, one per cycle.
module rf_clear_fsm
  import rf_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_clr_we,
  output logic [$clog2(DEPTH)-1:0] o_clr_addr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rf_state_e     r_state;
  logic [AW-1:0] r_cnt;
  logic          r_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          // Leave on the edge that clears the last address.
          if (r_cnt == LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_clr_we   = r_busy;
  assign o_clr_addr = r_cnt;
endmodule

// File: rtl/rf_sb_multiport.sv
// Multiport register file with per-register pending bits and a bulk-clear engine.
// Define RF_BYPASS_EN to forward same-cycle write data to matching read ports.
module rf_sb_multiport
  import rf_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  rf_sb_multiport_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [DEPTH-1:0]     r_pend;

  logic                 w_clr_busy;
  logic                 w_clr_we;
  logic [AW-1:0]        w_clr_addr;
  logic                 w_wr_ok;
  logic                 w_rsv_ok;
  logic [AW-1:0]        w_ra;
  logic [NRD*WIDTH-1:0] w_rd;
  logic [NRD-1:0]       w_rbusy;

  rf_clear_fsm #(.DEPTH(DEPTH)) u_clear (
    .clk        (clk),
    .reset      (reset),
    .i_start    (bus.clr_start),
    .o_busy     (w_clr_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  // Register 0 is hard-wired when ZERO_REG is set: no writes, no reservations.
  assign w_wr_ok  = bus.we  && !((ZERO_REG != 0) && (bus.wa == '0));
  assign w_rsv_ok = bus.rsv && !((ZERO_REG != 0) && (bus.rsv_a == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_pend <= '0;
    end else if (w_clr_we) begin
      r_mem[w_clr_addr]  <= '0;
      r_pend[w_clr_addr] <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_mem[bus.wa]  <= bus.wd;
        r_pend[bus.wa] <= 1'b0;
      end
      // Reservation is younger than the retiring write, so it wins on a shared address.
      if (w_rsv_ok) r_pend[bus.rsv_a] <= 1'b1;
    end
  end

  always_comb begin
    w_rd    = '0;
    w_rbusy = '0;
    w_ra    = '0;
    for (int i = 0; i < NRD; i++) begin
      w_ra = `RF_SLICE(bus.ra, i, AW);
      if (w_clr_busy || ((ZERO_REG != 0) && (w_ra == '0))) begin
        `RF_SLICE(w_rd, i, WIDTH) = '0;
        w_rbusy[i]                = 1'b0;
`ifdef RF_BYPASS_EN
      end else if (w_wr_ok && (w_ra == bus.wa)) begin
        `RF_SLICE(w_rd, i, WIDTH) = bus.wd;
        w_rbusy[i]                = 1'b0;
`endif
      end else begin
        `RF_SLICE(w_rd, i, WIDTH) = r_mem[w_ra];
        w_rbusy[i]                = r_pend[w_ra];
      end
    end
  end

  assign bus.rd       = w_rd;
  assign bus.rbusy    = w_rbusy;
  assign bus.clr_busy = w_clr_busy;
endmodule

// File: tb/tb_rf_sb_multiport.sv
// Self-checking bench for rf_sb_multiport against an array-based reference model.
module tb_rf_sb_multiport;
  localparam int W = 32;
  localparam int D = 32;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  rf_sb_multiport_if #(.WIDTH(W), .DEPTH(D), .NRD(2)) bus ();

  rf_sb_multiport #(.WIDTH(W), .DEPTH(D), .NRD(2), .ZERO_REG(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] m_mem [D];
  bit           m_pend[D];
  int           m_clr;

  function automatic logic [W-1:0] exp_rd(int a);
    if (m_clr > 0 || a == 0) return '0;
`ifdef RF_BYPASS_EN
    if (bus.we && int'(bus.wa) == a) return bus.wd;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(int a);
    if (m_clr > 0 || a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
    if (bus.we && int'(bus.wa) == a) return 1'b0;
`endif
    return m_pend[a];
  endfunction

  task automatic tick();
    if (reset) begin
      for (int i = 0; i < D; i++) begin m_mem[i] = '0; m_pend[i] = 0; end
      m_clr = 0;
    end else if (m_clr > 0) begin
      m_clr--;
    end else if (bus.clr_start) begin
      for (int i = 0; i < D; i++) begin m_mem[i] = '0; m_pend[i] = 0; end
      m_clr = D;
    end else begin
      if (bus.we && bus.wa != 0) begin m_mem[bus.wa] = bus.wd; m_pend[bus.wa] = 0; end
      if (bus.rsv && bus.rsv_a != 0) m_pend[bus.rsv_a] = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.we = 0; bus.wa = '0; bus.wd = '0; bus.rsv = 0; bus.rsv_a = '0; bus.clr_start = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs(); bus.ra = '0;
    tick();
    reset = 0;
    for (int a = 0; a < D; a++) begin
      bus.ra = {5'(D - 1 - a), 5'(a)};
      #2;
      for (int p = 0; p < 2; p++) begin
        n_tests++;
        if (bus.rd[p*W +: W] !== '0 || bus.rbusy[p] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_read p%0d ra=%0d: got rd=%0h busy=%b, want 0/0", p, bus.ra[p*5 +: 5], bus.rd[p*W +: W], bus.rbusy[p]);
        end
      end
    end
    n_tests++;
    if (bus.clr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_clr_busy got %b want 0", bus.clr_busy); end
  endtask

  task automatic test_write();
    bus.we = 0; bus.wa = 5'd19; bus.wd = 121; tick();
    bus.we = 1; bus.wa = 5'd13; bus.wd = 45;  tick();
    idle_inputs();
    bus.ra = {5'd13, 5'd19};
    #2;
    n_tests++;
    if (bus.rd[0 +: W] !== 32'd0) begin n_fail++; $display("FAIL write_disabled rd0 got %0d want 0", bus.rd[0 +: W]); end
    n_tests++;
    if (bus.rd[W +: W] !== 32'd45) begin n_fail++; $display("FAIL write_enabled rd1 got %0d want 45", bus.rd[W +: W]); end
  endtask

  task automatic test_reserve();
    bus.rsv = 1; bus.rsv_a = 5'd7; tick();
    idle_inputs(); bus.ra = {5'd7, 5'd7}; #2;
    n_tests++;
    if (bus.rbusy !== 2'b11) begin n_fail++; $display("FAIL reserve_busy got %b want 11", bus.rbusy); end
    bus.we = 1; bus.wa = 5'd7; bus.wd = 9; #2;
    n_tests++;
    if (bus.rd[0 +: W] !== exp_rd(7) || bus.rbusy[0] !== exp_busy(7)) begin
      n_fail++; $display("FAIL reserve_prewrite got rd=%0d busy=%b want rd=%0d busy=%b", bus.rd[0 +: W], bus.rbusy[0], exp_rd(7), exp_busy(7));
    end
    tick(); idle_inputs(); #2;
    n_tests++;
    if (bus.rbusy[0] !== 1'b0 || bus.rd[0 +: W] !== 32'd9) begin
      n_fail++; $display("FAIL reserve_writeback got rd=%0d busy=%b want 9/0", bus.rd[0 +: W], bus.rbusy[0]);
    end
    bus.we = 1; bus.wa = 5'd8; bus.wd = 32'hABCD; bus.rsv = 1; bus.rsv_a = 5'd8; tick();
    idle_inputs(); bus.ra = {5'd8, 5'd8}; #2;
    n_tests++;
    if (bus.rbusy[1] !== 1'b1 || bus.rd[W +: W] !== 32'hABCD) begin
      n_fail++; $display("FAIL same_edge_rsv_we got rd=%0h busy=%b want abcd/1", bus.rd[W +: W], bus.rbusy[1]);
    end
  endtask

  task automatic test_zero_reg();
    bus.we = 1; bus.wa = '0; bus.wd = 5; bus.rsv = 1; bus.rsv_a = '0; tick();
    idle_inputs(); bus.ra = '0; #2;
    n_tests++;
    if (bus.rd[0 +: W] !== '0 || bus.rbusy[0] !== 1'b0) begin
      n_fail++; $display("FAIL zero_reg got rd=%0d busy=%b want 0/0", bus.rd[0 +: W], bus.rbusy[0]);
    end
  endtask

  task automatic test_clear();
    for (int a = 1; a < D; a++) begin bus.we = 1; bus.wa = 5'(a); bus.wd = a; tick(); end
    idle_inputs(); bus.clr_start = 1; tick();
    for (int c = 0; c < D; c++) begin
      bus.clr_start = 1'($urandom_range(0, 1));
      bus.we = 1; bus.wa = 5'($urandom_range(1, D - 1)); bus.wd = $urandom;
      bus.rsv = 1; bus.rsv_a = 5'($urandom_range(1, D - 1));
      bus.ra = 10'($urandom);
      #2;
      n_tests++;
      if (bus.clr_busy !== 1'b1 || bus.rd !== '0 || bus.rbusy !== '0) begin
        n_fail++; $display("FAIL clear_cycle%0d got busy=%b rd=%0h rbusy=%b want 1/0/0", c, bus.clr_busy, bus.rd, bus.rbusy);
      end
      tick();
    end
    idle_inputs(); #2;
    n_tests++;
    if (bus.clr_busy !== 1'b0) begin n_fail++; $display("FAIL clear_end_busy got %b want 0", bus.clr_busy); end
    for (int a = 0; a < D; a++) begin
      bus.ra = {5'(a), 5'(a)}; #2;
      n_tests++;
      if (bus.rd !== '0 || bus.rbusy !== '0 || bus.rd[0 +: W] !== exp_rd(a)) begin
        n_fail++; $display("FAIL clear_after ra=%0d got rd=%0h rbusy=%b want 0", a, bus.rd, bus.rbusy);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    for (int a = 1; a < 6; a++) begin bus.we = 1; bus.wa = 5'(a); bus.wd = 100 + a; bus.rsv = 1; bus.rsv_a = 5'(a + 10); tick(); end
    idle_inputs(); bus.clr_start = 1; tick();
    idle_inputs();
    for (int c = 0; c < 9; c++) tick();
    reset = 1; tick(); reset = 0;
    #2;
    n_tests++;
    if (bus.clr_busy !== 1'b0) begin n_fail++; $display("FAIL midclear_busy got %b want 0", bus.clr_busy); end
    for (int a = 0; a < D; a++) begin
      bus.ra = {5'(a), 5'(a)}; #2;
      n_tests++;
      if (bus.rd !== '0 || bus.rbusy !== '0) begin
        n_fail++; $display("FAIL midclear_read ra=%0d got rd=%0h rbusy=%b want 0", a, bus.rd, bus.rbusy);
      end
    end
  endtask

  task automatic test_bypass();
    bus.we = 1; bus.wa = 5'd3; bus.wd = 11; tick();
    bus.rsv = 1; bus.rsv_a = 5'd3; bus.we = 0; tick();
    idle_inputs();
    bus.we = 1; bus.wa = 5'd3; bus.wd = 77; bus.ra = {5'd3, 5'd3}; #2;
    n_tests++;
    if (bus.rd[0 +: W] !== exp_rd(3) || bus.rbusy[0] !== exp_busy(3)) begin
      n_fail++; $display("FAIL bypass_same_cycle got rd=%0d busy=%b want rd=%0d busy=%b", bus.rd[0 +: W], bus.rbusy[0], exp_rd(3), exp_busy(3));
    end
    tick(); idle_inputs(); #2;
    n_tests++;
    if (bus.rd[W +: W] !== 32'd77 || bus.rbusy[1] !== 1'b0) begin
      n_fail++; $display("FAIL bypass_after_edge got rd=%0d busy=%b want 77/0", bus.rd[W +: W], bus.rbusy[1]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset         = ($urandom_range(0, 199) == 0);
      bus.we        = 1'($urandom);
      bus.wa        = 5'($urandom);
      bus.wd        = $urandom;
      bus.rsv       = 1'($urandom);
      bus.rsv_a     = ($urandom_range(0, 3) == 0) ? bus.wa : 5'($urandom);
      bus.clr_start = ($urandom_range(0, 79) == 0);
      bus.ra        = ($urandom_range(0, 3) == 0) ? {5'($urandom), bus.wa} : 10'($urandom);
      #2;
      for (int p = 0; p < 2; p++) begin
        n_tests++;
        if (bus.rd[p*W +: W] !== exp_rd(bus.ra[p*5 +: 5]) || bus.rbusy[p] !== exp_busy(bus.ra[p*5 +: 5])) begin
          n_fail++;
          $display("FAIL random c%0d p%0d ra=%0d got rd=%0h busy=%b want rd=%0h busy=%b", c, p, bus.ra[p*5 +: 5],
                   bus.rd[p*W +: W], bus.rbusy[p], exp_rd(bus.ra[p*5 +: 5]), exp_busy(bus.ra[p*5 +: 5]));
        end
      end
      n_tests++;
      if (bus.clr_busy !== (m_clr > 0)) begin
        n_fail++; $display("FAIL random_clr_busy c%0d got %b want %b", c, bus.clr_busy, m_clr > 0);
      end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    m_clr = 0;
    for (int i = 0; i < D; i++) begin m_mem[i] = '0; m_pend[i] = 0; end
    reset = 1; idle_inputs(); bus.ra = '0;
    @(posedge clk); #1;
    test_reset();
    test_write();
    test_reserve();
    test_zero_reg();
    test_clear();
    test_reset_mid_clear();
    test_bypass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
